// File: rtl/rvsteel_spi_target_if.sv
// Bundle of the SPI pad signals and the byte-level local interface of rvsteel_spi_target.
//   slave  : the target itself (drives poci/poci_oe, tx_ready, rx_*, tx_underrun, busy).
//   master : the controller plus local logic (drives cpol/cpha, sclk, pico, cs, tx_data/tx_valid).
interface rvsteel_spi_target_if;
   logic       cpol;
   logic       cpha;
   logic       sclk;
   logic       pico;
   logic       cs;
   logic       poci;
   logic       poci_oe;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_underrun;
   logic       busy;

   modport slave (
      input  cpol, cpha, sclk, pico, cs, tx_data, tx_valid,
      output poci, poci_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
   );

   modport master (
      output cpol, cpha, sclk, pico, cs, tx_data, tx_valid,
      input  poci, poci_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
   );
endinterface

// File: rtl/rvsteel_spi_target.sv
// SPI target for the RVSteel SPI controller. Oversamples sclk/pico/cs in the local clock
// domain, supports CPOL/CPHA modes 0-3 with 8-bit MSB-first frames.
// Ports:
//   clock    system clock, at least 8x sclk
//   reset_n  asynchronous active-low reset
//   bus      rvsteel_spi_target_if.slave: SPI pads (cpol, cpha, sclk, pico, cs, poci, poci_oe)
//            and local byte interface (tx_data/tx_valid/tx_ready, rx_data/rx_valid,
//            tx_underrun, busy)
module rvsteel_spi_target #(
   parameter logic [7:0] TX_IDLE_BYTE = 8'hFF
) (
   input logic                 clock,
   input logic                 reset_n,
   rvsteel_spi_target_if.slave bus
);

   typedef enum logic {StIdle, StActive} state_e;

   state_e state_q, state_d;

   // Synchronizers; the *_prev_q stage exists only for edge detection.
   logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
   logic pico_meta_q, pico_sync_q;
   logic cs_meta_q, cs_sync_q, cs_prev_q;

   // fill_q marks when the cs chain holds real pad samples rather than reset values; a frame
   // is only accepted once cs has been seen high after that, so a cs already low at reset
   // release is ignored until it toggles.
   logic [1:0] fill_q;
   logic       armed_q;

   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_pend_q, rx_pend_d;
   logic       rx_valid_q;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   logic       underrun_q, underrun_d;

   logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge, cs_fall;
   logic start, stop, sample, shift, active;
   logic last_bit, load, shift_left, write;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sclk_meta_q <= 1'b0;
         sclk_sync_q <= 1'b0;
         sclk_prev_q <= 1'b0;
         pico_meta_q <= 1'b0;
         pico_sync_q <= 1'b0;
         cs_meta_q   <= 1'b1;
         cs_sync_q   <= 1'b1;
         cs_prev_q   <= 1'b1;
         fill_q      <= 2'b00;
         armed_q     <= 1'b0;
      end else begin
         sclk_meta_q <= bus.sclk;
         sclk_sync_q <= sclk_meta_q;
         sclk_prev_q <= sclk_sync_q;
         pico_meta_q <= bus.pico;
         pico_sync_q <= pico_meta_q;
         cs_meta_q   <= bus.cs;
         cs_sync_q   <= cs_meta_q;
         cs_prev_q   <= cs_sync_q;
         fill_q      <= {fill_q[0], 1'b1};
         if (fill_q[1] && cs_sync_q) begin
            armed_q <= 1'b1;
         end
      end
   end

   assign sclk_rise   = sclk_sync_q & ~sclk_prev_q;
   assign sclk_fall   = ~sclk_sync_q & sclk_prev_q;
   assign lead_edge   = bus.cpol ? sclk_fall : sclk_rise;
   assign trail_edge  = bus.cpol ? sclk_rise : sclk_fall;
   assign sample_edge = bus.cpha ? trail_edge : lead_edge;
   assign shift_edge  = bus.cpha ? lead_edge : trail_edge;
   assign cs_fall     = armed_q & cs_prev_q & ~cs_sync_q;

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (cs_fall)   state_d = StActive;
         StActive: if (cs_sync_q) state_d = StIdle;
      endcase
   end

   // FSM outputs; sclk edges only count while cs is still low
   always_comb begin
      start  = 1'b0;
      stop   = 1'b0;
      sample = 1'b0;
      shift  = 1'b0;
      active = 1'b0;
      unique case (state_q)
         StIdle: start = cs_fall;
         StActive: begin
            active = 1'b1;
            if (cs_sync_q) begin
               stop = 1'b1;
            end else begin
               sample = sample_edge;
               shift  = shift_edge;
            end
         end
      endcase
   end

   assign last_bit = (bit_cnt_q == 3'd7);
   // cpha=0 reloads on the shift edge that opens a byte; cpha=1 reloads on the sample edge
   // that closes one and then holds on the following shift edge (bit_cnt==0).
   assign load       = start | (bus.cpha ? (sample & last_bit)
                                         : (shift & (bit_cnt_q == 3'd0)));
   assign shift_left = shift & (bit_cnt_q != 3'd0);
   assign write      = bus.tx_valid & ~hold_full_q;

   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data_q;
      rx_pend_d   = 1'b0;
      tx_shift_d  = tx_shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      underrun_d  = 1'b0;

      if (start || stop) begin
         bit_cnt_d = 3'd0;
      end else if (sample) begin
         bit_cnt_d  = bit_cnt_q + 3'd1;
         rx_shift_d = {rx_shift_q[6:0], pico_sync_q};
         if (last_bit) begin
            rx_data_d = {rx_shift_q[6:0], pico_sync_q};
            rx_pend_d = 1'b1;
         end
      end

      if (load) begin
         tx_shift_d  = hold_full_q ? hold_q : TX_IDLE_BYTE;
         hold_full_d = 1'b0;
         underrun_d  = ~hold_full_q;
      end else if (shift_left) begin
         tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end

      // A write in the load cycle lands after the load has taken the old contents.
      if (write) begin
         hold_d      = bus.tx_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt_q   <= 3'd0;
         rx_shift_q  <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_pend_q   <= 1'b0;
         rx_valid_q  <= 1'b0;
         tx_shift_q  <= 8'h00;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         rx_data_q   <= rx_data_d;
         rx_pend_q   <= rx_pend_d;
         rx_valid_q  <= rx_pend_q;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         underrun_q  <= underrun_d;
      end
   end

   assign bus.poci        = active & tx_shift_q[7];
   assign bus.poci_oe     = active;
   assign bus.busy        = active;
   assign bus.tx_ready    = ~hold_full_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.tx_underrun = underrun_q;

endmodule
